// File: rtl/control_unit_fsm.sv
// Multicycle control sequencer: fetch/decode/execute/memory/writeback with per-lane vector iteration.
// Optional build macro CU_ILLEGAL_TRAP_EN: illegal opcodes lock into a TRAP state until reset.
//
// state   | meaning
// FETCH   | read instruction at PC, PC+4 on ready
// DECODE  | PC+8 precompute, dispatch on Opcode/CondEx
// EXEC    | ALU operation, reg or immediate operand B
// ALUWB   | write ALU result to Rd (or PC when Rd=15)
// MEMADR  | address = base + offset
// MEMRD   | memory read, wait for ready
// MEMWB   | write load data to Rd (or PC)
// MEMWR   | memory write, wait for ready
// BRANCH  | PC <= PC+8 + branch offset
// TRAP    | illegal opcode lock (macro build only)
module control_unit_fsm #(
  parameter int LANES  = 4,
  parameter int LANE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        Opcode,
  input  logic              V,
  input  logic [2:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic              CondEx,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              MemW,
  output logic              AdrSrc,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              RegW,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        ResultSrc,
  output logic              alu_op,
  output logic [LANE_W-1:0] lane,
  output logic              busy,
  output logic              trap
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_TRAP
  } state_t;

  state_t            state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              last_lane;
  logic              rd_is_pc;
  logic              trap_c;
  logic              unused_funct;

  // Only Funct[0] steers the sequencer; the upper bits go straight to the ALU decoder.
  assign unused_funct = ^Funct[2:1];
  assign last_lane    = !V || (lane_q == LANE_W'(LANES - 1));
  assign rd_is_pc     = (Rd == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    mem_req   = 1'b0;
    MemW      = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegW      = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ImmSrc    = 2'b00;
    ResultSrc = 2'b00;
    alu_op    = 1'b0;
    busy      = (state_q != S_FETCH) && (state_q != S_TRAP);
    trap_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (!CondEx) begin
          state_d = S_FETCH;
        end else begin
          case (Opcode)
            3'b000, 3'b001: state_d = S_EXEC;
            3'b010:         state_d = S_MEMADR;
            3'b011:         state_d = S_BRANCH;
`ifdef CU_ILLEGAL_TRAP_EN
            default:        state_d = S_TRAP;
`else
            default:        state_d = S_FETCH;
`endif
          endcase
        end
      end
      S_EXEC: begin
        alu_op = 1'b1;
        if (Opcode == 3'b001) ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        PCWrite = rd_is_pc;
        RegW    = !rd_is_pc;
        if (last_lane) begin
          lane_d  = '0;
          state_d = S_FETCH;
        end else begin
          lane_d  = lane_q + LANE_W'(1);
          state_d = S_EXEC;
        end
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        PCWrite   = rd_is_pc;
        RegW      = !rd_is_pc;
        if (last_lane) begin
          lane_d  = '0;
          state_d = S_FETCH;
        end else begin
          lane_d  = lane_q + LANE_W'(1);
          state_d = S_MEMADR;
        end
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        MemW    = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          if (last_lane) begin
            lane_d  = '0;
            state_d = S_FETCH;
          end else begin
            lane_d  = lane_q + LANE_W'(1);
            state_d = S_MEMADR;
          end
        end
      end
      S_BRANCH: begin
        ImmSrc    = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        lane_d    = '0;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        trap_c = 1'b1;
      end
      default: begin
        lane_d  = '0;
        state_d = S_FETCH;
      end
    endcase

    // Reset forces every output low even though FETCH would otherwise request memory.
    if (!rst_n) begin
      mem_req   = 1'b0;
      MemW      = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegW      = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ImmSrc    = 2'b00;
      ResultSrc = 2'b00;
      alu_op    = 1'b0;
      busy      = 1'b0;
      trap_c    = 1'b0;
    end
  end

  assign lane = lane_q;

`ifdef CU_ILLEGAL_TRAP_EN
  assign trap = trap_c;
`else
  logic unused_trap_c;
  assign unused_trap_c = trap_c;
  assign trap          = 1'b0;
`endif

endmodule
